apb4_master: RTL and testbench



---
 rtl/apb4_master.sv | 188 ++++++++++++++++++
 tb/tb_apb4_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
`default_nettype none
// ============================================================================
// Module      : apb4_master
// Description : Single-outstanding APB4 initiator. Converts a valid/ready
//               request/response channel into APB4 SETUP/ACCESS transfers,
//               handles slave wait states, captures pslverr and aborts a
//               transfer when the slave holds pready low for too long.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    presetn,

    // Request channel
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,

    // Response channel
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,

    output logic                    busy_o,

    // APB4 master outputs
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,

    // APB4 slave returns
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    // Wide enough to hold TIMEOUT_CYCLES itself; at least one bit.
    localparam int c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic                    write_q,   write_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [c_STRB_W-1:0]     strb_q,    strb_d;
    logic [2:0]              prot_q,    prot_d;
    logic [c_CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    err_q,     err_d;
    logic                    tmo_q,     tmo_d;

    logic [c_CNT_W-1:0]      w_cnt_inc;
    logic                    w_limit;

    // Saturating increment; the limit is hit when this cycle's wait makes the
    // count equal to TIMEOUT_CYCLES.
    assign w_cnt_inc = (cnt_q == {c_CNT_W{1'b1}}) ? cnt_q : cnt_q + c_CNT_W'(1);
    assign w_limit   = c_TO_EN && (w_cnt_inc == c_TO_LIMIT);

    // State register and transfer/response holding registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic: request capture, wait/timeout handling, response hold.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    write_d = req_write_i;
                    wdata_d = req_wdata_i;
                    // Reads never carry strobes on the bus.
                    strb_d  = req_write_i ? req_strb_i : '0;
                    prot_d  = req_prot_i;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                // Slave completion wins over a timeout in the same cycle.
                if (pready) begin
                    rdata_d = write_q ? '0 : prdata;
                    err_d   = pslverr;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (w_limit) begin
                    cnt_d   = w_cnt_inc;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = w_cnt_inc;
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of flops; no APB input reaches them combinationally.
    assign req_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign psel          = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable       = (state_q == ST_ACCESS);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;

    assign paddr  = addr_q;
    assign pwrite = write_q;
    assign pwdata = wdata_q;
    assign pstrb  = strb_q;
    assign pprot  = prot_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_master
// Description : Directed self-checking bench for apb4_master (TIMEOUT 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_master;

    logic        pclk;
    logic        presetn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;

    apb4_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_write_i   (req_write_i),
        .req_wdata_i   (req_wdata_i),
        .req_strb_i    (req_strb_i),
        .req_prot_i    (req_prot_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .paddr         (paddr),
        .pwrite        (pwrite),
        .pwdata        (pwdata),
        .pstrb         (pstrb),
        .pprot         (pprot),
        .psel          (psel),
        .penable       (penable),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present a request while IDLE and let the next edge accept it.
    // On return the bench sits in cycle T+1 (SETUP).
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = d;
        req_strb_i  = s;
        req_prot_i  = p;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        presetn     = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        req_prot_i  = '0;
        rsp_ready_i = 1'b0;
        prdata      = '0;
        pready      = 1'b0;
        pslverr     = 1'b0;

        // ---------------- Reset state ----------------
        tick(); tick();
        check("rst_req_ready", req_ready_o, 1);
        check("rst_psel",      psel,        0);
        check("rst_penable",   penable,     0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_busy",      busy_o,      0);
        check("rst_paddr",     paddr,       0);
        check("rst_rsp_err",   rsp_err_o,   0);
        presetn = 1'b1;
        tick();

        // ---------------- Zero-wait write ----------------
        issue(32'h08, 1'b1, 32'hA5A5_0003, 4'hF, 3'b010);
        check("wr_t1_psel",    psel,        1);
        check("wr_t1_penable", penable,     0);
        check("wr_t1_ready",   req_ready_o, 0);
        check("wr_t1_busy",    busy_o,      1);
        pready = 1'b1;
        tick();
        check("wr_t2_penable", penable, 1);
        check("wr_t2_pwrite",  pwrite,  1);
        check("wr_t2_pstrb",   pstrb,   4'hF);
        check("wr_t2_paddr",   paddr,   32'h08);
        check("wr_t2_pwdata",  pwdata,  32'hA5A5_0003);
        check("wr_t2_pprot",   pprot,   3'b010);
        tick();
        pready = 1'b0;
        check("wr_t3_rsp_valid", rsp_valid_o,   1);
        check("wr_t3_rsp_err",   rsp_err_o,     0);
        check("wr_t3_rsp_rdata", rsp_rdata_o,   0);
        check("wr_t3_rsp_tmo",   rsp_timeout_o, 0);
        check("wr_t3_psel",      psel,          0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("wr_done_rsp_valid", rsp_valid_o, 0);
        check("wr_done_req_ready", req_ready_o, 1);

        // ---------------- Read with 3 wait states ----------------
        issue(32'h0C, 1'b0, 32'h1111_2222, 4'hF, 3'b001);
        check("rd_t1_pstrb", pstrb, 0);
        prdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait_penable",   penable,     1);
            check("rd_wait_psel",      psel,        1);
            check("rd_wait_paddr",     paddr,       32'h0C);
            check("rd_wait_pwrite",    pwrite,      0);
            check("rd_wait_pstrb",     pstrb,       0);
            check("rd_wait_rsp_valid", rsp_valid_o, 0);
        end
        tick();
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        check("rd_t5_penable", penable, 1);
        tick();
        pready = 1'b0;
        prdata = 32'h0;
        check("rd_t6_rsp_valid", rsp_valid_o, 1);
        check("rd_t6_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        check("rd_t6_rsp_err",   rsp_err_o,   0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---------------- Slave error ----------------
        issue(32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
        pready  = 1'b1;
        pslverr = 1'b1;
        tick();
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        check("err_rsp_valid", rsp_valid_o,   1);
        check("err_rsp_err",   rsp_err_o,     1);
        check("err_rsp_tmo",   rsp_timeout_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---------------- Timeout: pready stuck low ----------------
        issue(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
        prdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_access_penable", penable,     1);
            check("to_access_rsp_vld", rsp_valid_o, 0);
        end
        tick();
        check("to_psel",      psel,          0);
        check("to_penable",   penable,       0);
        check("to_rsp_valid", rsp_valid_o,   1);
        check("to_rsp_err",   rsp_err_o,     1);
        check("to_rsp_tmo",   rsp_timeout_o, 1);
        check("to_rsp_rdata", rsp_rdata_o,   0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---------------- pready on the 4th ACCESS cycle: no timeout ----------------
        issue(32'h24, 1'b0, 32'h0, 4'h0, 3'b000);
        tick(); tick(); tick();
        tick();
        check("lim_t5_psel", psel, 1);
        pready = 1'b1;
        prdata = 32'hCAFE_0004;
        tick();
        pready = 1'b0;
        prdata = 32'h0;
        check("lim_rsp_valid", rsp_valid_o,   1);
        check("lim_rsp_err",   rsp_err_o,     0);
        check("lim_rsp_tmo",   rsp_timeout_o, 0);
        check("lim_rsp_rdata", rsp_rdata_o,   32'hCAFE_0004);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---------------- Response backpressure ----------------
        issue(32'h30, 1'b1, 32'h0000_0030, 4'h3, 3'b000);
        pready = 1'b1;
        tick();
        tick();
        pready = 1'b0;
        // Pending request waiting for the initiator.
        req_addr_i  = 32'h40;
        req_write_i = 1'b0;
        req_strb_i  = 4'h0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid_o, 1);
            check("bp_req_ready", req_ready_o, 0);
            check("bp_rsp_err",   rsp_err_o,   0);
            check("bp_psel",      psel,        0);
            tick();
        end
        check("bp_paddr_hold", paddr, 32'h30);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("bp_r1_req_ready", req_ready_o, 1);
        check("bp_r1_psel",      psel,        0);
        check("bp_r1_rsp_valid", rsp_valid_o, 0);
        tick();
        req_valid_i = 1'b0;
        check("bp_r2_psel",  psel,  1);
        check("bp_r2_paddr", paddr, 32'h40);
        pready = 1'b1;
        prdata = 32'h0000_4040;
        tick();
        tick();
        pready = 1'b0;
        check("bp_rd_rdata", rsp_rdata_o, 32'h0000_4040);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // ---------------- Reset pulse during ACCESS ----------------
        issue(32'h50, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
        check("rstmid_penable_before", penable, 1);
        #2;
        presetn = 1'b0;
        #1;
        check("rstmid_psel_async",    psel,    0);
        check("rstmid_penable_async", penable, 0);
        tick();
        check("rstmid_rsp_valid", rsp_valid_o, 0);
        presetn = 1'b1;
        tick();
        check("rstmid_rsp_valid2", rsp_valid_o, 0);
        check("rstmid_req_ready",  req_ready_o, 1);
        issue(32'h60, 1'b0, 32'h0, 4'h0, 3'b000);
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        tick();
        tick();
        pready = 1'b0;
        check("post_rst_rsp_valid", rsp_valid_o, 1);
        check("post_rst_rsp_rdata", rsp_rdata_o, 32'h0BAD_F00D);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
